rom_read_arbiter: RTL

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rom_read_arbiter
// Purpose  : Round-robin arbiter granting two requesters burst read access to
//            a shared combinational ROM. A granted burst of 1..8 beats reads
//            consecutive addresses (wrapping modulo 2^ADDR_W) and returns the
//            data on a registered read channel.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req0/1, addr0/1, len0/1    - burst requests (addr/len sampled at grant)
//            gnt0/1                     - grant, held for the whole burst
//            rom_addr / rom_data        - shared ROM address out / data in
//            rvalid, rlast, rid, rdata  - registered read beat channel
//            busy                       - high whenever the arbiter is not idle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_read_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [2:0]        len0,
  input  logic [2:0]        len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rvalid,
  output logic              rlast,
  output logic              rid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        cnt;
  // Index of the most recent grant; doubles as the owner of the active burst.
  logic              last_gnt;
  logic              winner;

  // On a tie the requester not granted last time wins; otherwise the sole
  // requester wins.
  assign winner = (req0 && req1) ? ~last_gnt : req1;

  // The only combinational output: the ROM is addressed only while beats
  // are being issued.
  assign rom_addr = (state == BURST) ? ptr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= BURST;
            busy     <= 1'b1;
            gnt0     <= ~winner;
            gnt1     <= winner;
            last_gnt <= winner;
            ptr      <= winner ? addr1 : addr0;
            cnt      <= winner ? len1 : len0;
          end
        end
        BURST: begin
          rdata  <= rom_data;
          rvalid <= 1'b1;
          rid    <= last_gnt;
          ptr    <= ptr + 1'b1;
          if (cnt == 3'd0) begin
            rlast <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          // Final beat is visible this cycle; release the grant next.
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
